// File: rtl/capture_burst_packer_if.sv
// capture_burst_packer_if: stream of packed 64-bit beats with SOF and burst-end flags.
interface capture_burst_packer_if;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        m_user;
    modport master(output m_data, m_valid, m_last, m_user, input m_ready);
    modport slave(input m_data, m_valid, m_last, m_user, output m_ready);
endinterface

// File: rtl/capture_burst_packer.sv
// capture_burst_packer: packs RGB565 pixels four per 64-bit beat, buffers them and frames fixed bursts.
// The camera cannot stall, so a full FIFO drops beats and flags it.
module capture_burst_packer #(
    parameter int H_PIXELS    = 320,
    parameter int V_LINES     = 240,
    parameter int BURST_BEATS = 16,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                   p_clock,
    input  logic                   rst,
    input  logic [15:0]            pixel_data,
    input  logic                   pixel_valid,
    input  logic                   frame_done,
    input  logic [9:0]             x_count,
    input  logic [8:0]             y_count,
    capture_burst_packer_if.master beat,
    output logic                   frame_complete,
    output logic                   overflow,
    output logic                   sync_err,
    output logic [15:0]            drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(BURST_BEATS);
    localparam int FB = H_PIXELS * V_LINES / 4;
    localparam int FW = $clog2(FB + 1);

    typedef enum logic {DISARMED, ARMED} arm_t;

    arm_t          arm;
    logic [1:0]    lane;
    logic [47:0]   partial;
    logic          pending_sof;
    logic          pack_valid;
    logic          pack_sof;
    logic [63:0]   pack_data;
    logic [64:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [IW-1:0] beat_idx;
    logic [IW-1:0] cur_idx;
    logic [FW-1:0] frame_beats;
    logic [FW-1:0] next_beats;
    logic [64:0]   head;
    logic          realign;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic          unused_y;

    assign unused_y   = ^y_count;
    assign realign    = x_count == '0 && lane != '0;
    assign head       = mem[rd_ptr];
    assign full       = count == (AW + 1)'(FIFO_DEPTH);
    assign pop        = beat.m_valid && beat.m_ready;
    assign push       = pack_valid && (!full || pop);
    assign drop       = pack_valid && full && !pop;
    assign cur_idx    = head[64] ? '0 : beat_idx;
    assign next_beats = head[64] ? FW'(1) : frame_beats + FW'(1);

    assign beat.m_valid = count != '0;
    assign beat.m_data  = beat.m_valid ? head[63:0] : '0;
    assign beat.m_user  = beat.m_valid && head[64];
    assign beat.m_last  = beat.m_valid && cur_idx == IW'(BURST_BEATS - 1);

    // Pixels shift in from the top, so after three of them lane 0 sits in bits [15:0].
    always_ff @(posedge p_clock) begin
        if (rst) begin
            arm         <= DISARMED;
            lane        <= '0;
            partial     <= '0;
            pending_sof <= 1'b0;
            pack_valid  <= 1'b0;
            pack_sof    <= 1'b0;
            pack_data   <= '0;
            sync_err    <= 1'b0;
        end else begin
            pack_valid <= 1'b0;
            if (frame_done) begin
                arm         <= ARMED;
                lane        <= '0;
                pending_sof <= 1'b1;
            end else if (arm == ARMED && pixel_valid) begin
                partial  <= {pixel_data, partial[47:16]};
                lane     <= realign ? 2'd1 : lane + 2'd1;
                sync_err <= sync_err | realign;
                if (lane == 2'd3 && !realign) begin
                    pack_valid  <= 1'b1;
                    pack_data   <= {pixel_data, partial};
                    pack_sof    <= pending_sof;
                    pending_sof <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge p_clock) begin
        if (push) mem[wr_ptr] <= {pack_sof, pack_data};
    end

    // The frame counter stops at the frame size so the completion pulse fires once per SOF.
    always_ff @(posedge p_clock) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            beat_idx       <= '0;
            frame_beats    <= '0;
            frame_complete <= 1'b0;
            overflow       <= 1'b0;
            drop_count     <= '0;
        end else begin
            frame_complete <= 1'b0;
            count          <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                beat_idx <= cur_idx + IW'(1);
                if (head[64] || frame_beats != FW'(FB)) begin
                    frame_beats    <= next_beats;
                    frame_complete <= next_beats == FW'(FB);
                end
            end
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= drop_count + 16'(drop_count != '1);
            end
        end
    end
endmodule

// File: tb/tb_capture_burst_packer.sv
// tb_capture_burst_packer: directed pixel stimulus against a pixel-list model of the packed beat stream.
module tb_capture_burst_packer;
    localparam int FB    = 320 * 240 / 4;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [63:0] d;
        logic        s;
    } beat_t;

    logic        p_clock = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_done = 1'b0;
    logic [9:0]  x_count = '0;
    logic [8:0]  y_count = '0;
    logic        frame_complete;
    logic        overflow;
    logic        sync_err;
    logic [15:0] drop_count;

    capture_burst_packer_if bus();

    capture_burst_packer dut (
        .p_clock(p_clock),
        .rst(rst),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .frame_done(frame_done),
        .x_count(x_count),
        .y_count(y_count),
        .beat(bus),
        .frame_complete(frame_complete),
        .overflow(overflow),
        .sync_err(sync_err),
        .drop_count(drop_count)
    );

    always #5 p_clock = ~p_clock;

    int          total = 0;
    int          bad = 0;
    beat_t       q[$];
    logic [15:0] part[$];
    logic        armed = 1'b0;
    logic        pend_sof = 1'b0;
    int          n_pop = 0;
    int          n_user = 0;
    int          n_last = 0;
    int          n_fc = 0;
    int          first_user = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge p_clock);
            #1;
        end
    endtask

    // Model: collect pixels of the current word; four make a beat unless the FIFO is full.
    task automatic pix(input logic [15:0] d, input int x, input int y);
        beat_t b;
        pixel_data  = d;
        x_count     = 10'(x);
        y_count     = 9'(y);
        pixel_valid = 1'b1;
        if (armed) begin
            if (x == 0 && part.size() != 0) part.delete();
            part.push_back(d);
            if (part.size() == 4) begin
                b.d = {part[3], part[2], part[1], part[0]};
                b.s = pend_sof;
                if (q.size() < DEPTH) q.push_back(b);
                pend_sof = 1'b0;
                part.delete();
            end
        end
        @(posedge p_clock);
        #1;
        pixel_valid = 1'b0;
    endtask

    task automatic fdone();
        frame_done = 1'b1;
        armed      = 1'b1;
        pend_sof   = 1'b1;
        part.delete();
        @(posedge p_clock);
        #1;
        frame_done = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.m_valid) && n < 500) begin
            @(posedge p_clock);
            #1;
            n++;
        end
        chk("drain_bound", 64'(n < 500), 64'd1);
        idle(2);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_m_data"}, bus.m_data, 64'd0);
        chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
        chk({tag, "_m_last"}, 64'(bus.m_last), 64'd0);
        chk({tag, "_m_user"}, 64'(bus.m_user), 64'd0);
        chk({tag, "_frame_complete"}, 64'(frame_complete), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_sync_err"}, 64'(sync_err), 64'd0);
        chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        part.delete();
        armed    = 1'b0;
        pend_sof = 1'b0;
        @(posedge p_clock);
        #1;
        reset_vals("mid_rst");
        idle(2);
        rst = 1'b0;
    endtask

    // Beat checker: every popped beat against the model, plus stall stability and completion pulses.
    initial begin
        logic [63:0] pd;
        logic        pu;
        logic        pl;
        logic        stalled;
        logic        fc_due;
        int          pos;
        int          fpops;
        beat_t       e;
        pd = '0;
        pu = 1'b0;
        pl = 1'b0;
        stalled = 1'b0;
        fc_due = 1'b0;
        pos = 0;
        fpops = FB;
        forever begin
            @(negedge p_clock);
            if (rst) begin
                stalled    = 1'b0;
                fc_due     = 1'b0;
                pos        = 0;
                fpops      = FB;
                first_user = -1;
            end else begin
                chk("frame_complete", 64'(frame_complete), 64'(fc_due));
                fc_due = 1'b0;
                n_fc += int'(frame_complete);
                if (stalled) begin
                    chk("stall_valid", 64'(bus.m_valid), 64'd1);
                    chk("stall_data", bus.m_data, pd);
                    chk("stall_user", 64'(bus.m_user), 64'(pu));
                    chk("stall_last", 64'(bus.m_last), 64'(pl));
                end
                if (bus.m_valid && q.size() == 0) begin
                    chk("unexpected_beat", 64'(bus.m_valid), 64'd0);
                end else if (bus.m_valid && bus.m_ready) begin
                    e = q.pop_front();
                    pos = e.s ? 0 : pos + 1;
                    chk("beat_data", bus.m_data, e.d);
                    chk("beat_user", 64'(bus.m_user), 64'(e.s));
                    chk("beat_last", 64'(bus.m_last), 64'(pos % 16 == 15));
                    if (e.s) fpops = 0;
                    if (fpops < FB) begin
                        fpops++;
                        fc_due = fpops == FB;
                    end
                    n_pop++;
                    n_user += int'(bus.m_user);
                    n_last += int'(bus.m_last);
                    if (first_user < 0) first_user = int'(bus.m_user);
                end
                stalled = bus.m_valid && !bus.m_ready;
                pd = bus.m_data;
                pu = bus.m_user;
                pl = bus.m_last;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lasts;
        int p0;
        int u0;
        int l0;
        int f0;
        bus.m_ready = 1'b0;
        idle(3);
        reset_vals("por");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) pix(16'(i + 1), i, 0);
        idle(3);
        chk("unarmed_valid", 64'(bus.m_valid), 64'd0);

        fdone();
        pix(16'h1111, 0, 0);
        pix(16'h2222, 1, 0);
        pix(16'h3333, 2, 0);
        pix(16'h4444, 3, 0);
        @(negedge p_clock);
        chk("lat_early", 64'(bus.m_valid), 64'd0);
        @(negedge p_clock);
        chk("lat_valid", 64'(bus.m_valid), 64'd1);
        chk("basic_data", bus.m_data, 64'h4444_3333_2222_1111);
        chk("basic_user", 64'(bus.m_user), 64'd1);
        chk("basic_last", 64'(bus.m_last), 64'd0);
        @(posedge p_clock);
        #1;
        bus.m_ready = 1'b1;
        drain();

        chk("sync_err_clean", 64'(sync_err), 64'd0);
        bus.m_ready = 1'b0;
        pix(16'hA000, 0, 1);
        pix(16'hA001, 1, 1);
        pix(16'hB000, 0, 1);
        pix(16'hB001, 1, 1);
        pix(16'hB002, 2, 1);
        pix(16'hB003, 3, 1);
        @(negedge p_clock);
        @(negedge p_clock);
        chk("realign_sync_err", 64'(sync_err), 64'd1);
        chk("realign_data", bus.m_data, 64'hB003_B002_B001_B000);
        chk("realign_user", 64'(bus.m_user), 64'd0);
        @(posedge p_clock);
        #1;
        bus.m_ready = 1'b1;
        drain();

        bus.m_ready = 1'b0;
        fdone();
        for (int i = 0; i < 260; i++) pix(16'hC000 + 16'(i), i, 2);
        idle(3);
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_drop_count", 64'(drop_count), 64'd1);
        chk("bp_model_depth", 64'(q.size()), 64'd64);
        bus.m_ready = 1'b1;
        drain();

        fdone();
        for (int i = 0; i < 28; i++) pix(16'hD000 + 16'(i), i, 3);
        drain();
        lasts = n_last;
        pix(16'hDD00, 28, 3);
        pix(16'hDD01, 29, 3);
        fdone();
        for (int i = 0; i < 80; i++) pix(16'hE000 + 16'(i), i, 4);
        drain();
        chk("restart_lasts", 64'(n_last - lasts), 64'd1);

        bus.m_ready = 1'b0;
        fdone();
        for (int i = 0; i < 42; i++) pix(16'hF000 + 16'(i), i, 5);
        chk("pre_rst_valid", 64'(bus.m_valid), 64'd1);
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) pix(16'h0F00 + 16'(i), i, 6);
        idle(3);
        chk("post_rst_ignored", 64'(bus.m_valid), 64'd0);

        p0 = n_pop;
        u0 = n_user;
        l0 = n_last;
        f0 = n_fc;
        fdone();
        for (int y = 0; y < 240; y++)
            for (int x = 0; x < 320; x++) pix(16'(y * 320 + x), x, y);
        drain();
        idle(3);
        chk("ff_beats", 64'(n_pop - p0), 64'd19200);
        chk("ff_users", 64'(n_user - u0), 64'd1);
        chk("ff_lasts", 64'(n_last - l0), 64'd1200);
        chk("ff_complete", 64'(n_fc - f0), 64'd1);
        chk("ff_first_user", 64'(first_user), 64'd1);
        chk("ff_overflow", 64'(overflow), 64'd0);
        chk("ff_sync_err", 64'(sync_err), 64'd0);
        chk("ff_drop_count", 64'(drop_count), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
